pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the rvseed core.
- Owns the architectural fetch PC register and drives fetch requests to the instruction memory with a valid/ready handshake.
- Selects the next PC from, in priority order: trap, decode-stage branch/jump redirect, stall hold, sequential increment.
- Adds a boot state, misaligned-target detection with a halt state, and a flush pulse that squashes wrong-path instructions in IF/ID.

Parameters:
PC_W, 32, width of PC and of all address/data operands used for target computation.
RESET_PC, 32'h0000_0000, fetch address after reset; truncated to PC_W.
INST_BYTES, 4, sequential increment and target alignment in bytes; legal values 2 or 4.

Ports:
clk  in  1  core clock.
rst  in  1  synchronous reset, active-high.
stall  in  1  hazard-unit hold request.
branch  in  `BRAN_WIDTH  decode branch type (`BRAN_TYPE_A / `BRAN_TYPE_B / none).
zero  in  1  ALU zero flag for the decode-stage compare.
jump  in  `JUMP_WIDTH  decode jump type (`JUMP_JAL / `JUMP_JALR / none).
reg1_rdata  in  PC_W  rs1 value (JALR base).
imm  in  PC_W  sign-extended immediate.
idu_inst_pc  in  PC_W  PC of the instruction in decode.
trap_valid  in  1  trap/exception redirect request.
trap_pc  in  PC_W  trap handler address.
fetch_ready  in  1  instruction memory accepts request.
fetch_valid  out  1  fetch request valid.
fetch_pc  out  PC_W  fetch address.
flush  out  1  one-cycle pulse; squash IF/ID contents.
misalign_err  out  1  one-cycle pulse; redirect target misaligned.
misalign_addr  out  PC_W  offending target, held until next error or reset.
halted  out  1  high while in HALT state.

Behaviour:
- States: BOOT, RUN, HALT. All registers update only on rising clk.
- Reset (rst=1, dominates all inputs, including mid-handshake):
  - state=BOOT, fetch_pc=RESET_PC.
  - fetch_valid=0, flush=0, misalign_err=0, misalign_addr=0, halted=0.
- BOOT: unconditionally goes to RUN next cycle with fetch_pc unchanged. fetch_valid is first asserted one cycle after rst deasserts.
- RUN: fetch_valid=1. Next-PC priority:
  1. trap_valid: fetch_pc<=trap_pc with low log2(INST_BYTES) bits cleared; flush=1.
  2. Redirect taken when any of:
     - (branch==`BRAN_TYPE_A && zero)
     - (branch==`BRAN_TYPE_B && !zero)
     - jump==`JUMP_JAL; target=idu_inst_pc+imm.
     - jump==`JUMP_JALR; target=(reg1_rdata+imm) with bit0 cleared.
     - If the taken condition holds, the branch and JAL target is idu_inst_pc+imm.
     - Branch conditions take precedence over jump.
     - Target aligned (low log2(INST_BYTES) bits zero): fetch_pc<=target, flush=1.
     - Target misaligned: fetch_pc unchanged, misalign_err=1, misalign_addr<=target, flush=1, state<=HALT.
  3. stall: fetch_pc holds.
  4. fetch_valid && fetch_ready: fetch_pc<=fetch_pc+INST_BYTES.
  5. Otherwise hold; request stays stable until accepted.
- Redirects and traps ignore fetch_ready and stall; an unaccepted request is abandoned.
- HALT: fetch_valid=0, halted=1, fetch_pc frozen. Redirects and stall are ignored. trap_valid loads trap_pc, pulses flush and returns to RUN.
- Arithmetic is modulo 2^PC_W. Sequential increment from 2^PC_W-INST_BYTES wraps to 0 with no error.
- flush and misalign_err are registered, high exactly one cycle after the causing edge condition, and never high in BOOT.
- Simultaneous trap and misaligned redirect: trap wins, and no misalign_err is raised.

Test Plan:
- Reset release, fetch_ready=1 constant, RESET_PC=32'h8000_0000 -> fetch_valid=0 in BOOT; then fetch_pc 8000_0000, 8000_0004, 8000_0008 on consecutive cycles.
- fetch_ready low 3 cycles at pc 0x10 -> fetch_pc stays 0x10 with fetch_valid high; advances to 0x14 the cycle after ready returns.
- BRAN_TYPE_B, zero=0, idu_inst_pc=0x40, imm=-8, with stall=1 and fetch_ready=0 -> next fetch_pc=0x38 and flush pulses once. Repeat with zero=1 -> no redirect, pc holds.
- JALR, reg1_rdata=0x103, imm=0x0 -> target 0x102, misaligned for INST_BYTES=4 -> misalign_err pulse, misalign_addr=0x102, halted=1, fetch_valid=0. trap_valid with trap_pc=0x200 -> RUN at 0x200, flush pulse.
- Same-cycle trap_valid (trap_pc=0x300) and JAL (idu_inst_pc=0x0, imm=0x20) -> fetch_pc=0x300, no misalign_err.
- PC_W=16, fetch_pc=16'hFFFC, ready=1 -> next fetch_pc=0x0000. rst asserted mid-stall -> fetch_pc=RESET_PC, state BOOT next cycle.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch request channel between the PC generator and instruction memory.
//
// Handshake: fetch_valid/fetch_pc are driven by the master. A request
// transfers on a rising clk edge where fetch_valid && fetch_ready. While
// fetch_valid is high and fetch_ready is low, fetch_pc stays stable. The one
// exception is a redirect or trap: the pending request is then abandoned and
// replaced. fetch_ready may depend on fetch_valid, but fetch_valid never
// depends on fetch_ready.
interface pc_gen_if #(
  parameter int PC_W = 32
);
  logic            fetch_valid;
  logic [PC_W-1:0] fetch_pc;
  logic            fetch_ready;

  modport master (
    output fetch_valid,
    output fetch_pc,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_pc,
    output fetch_ready
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the rvseed core.
// Owns the architectural fetch PC and issues fetch requests over pc_gen_if.
// Next-PC priority in RUN: trap, decode redirect, stall hold, sequential step.
// A misaligned redirect target parks the block in HALT until a trap arrives.

`ifndef BRAN_WIDTH
`define BRAN_WIDTH 2
`endif
`ifndef BRAN_NONE
`define BRAN_NONE 2'd0
`endif
`ifndef BRAN_TYPE_A
`define BRAN_TYPE_A 2'd1
`endif
`ifndef BRAN_TYPE_B
`define BRAN_TYPE_B 2'd2
`endif
`ifndef JUMP_WIDTH
`define JUMP_WIDTH 2
`endif
`ifndef JUMP_NONE
`define JUMP_NONE 2'd0
`endif
`ifndef JUMP_JAL
`define JUMP_JAL 2'd1
`endif
`ifndef JUMP_JALR
`define JUMP_JALR 2'd2
`endif

module pc_gen #(
  parameter int          PC_W       = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          INST_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic [`BRAN_WIDTH-1:0] branch,
  input  logic                   zero,
  input  logic [`JUMP_WIDTH-1:0] jump,
  input  logic [PC_W-1:0]        reg1_rdata,
  input  logic [PC_W-1:0]        imm,
  input  logic [PC_W-1:0]        idu_inst_pc,
  input  logic                   trap_valid,
  input  logic [PC_W-1:0]        trap_pc,
  pc_gen_if.master               fetch,
  output logic                   flush,
  output logic                   misalign_err,
  output logic [PC_W-1:0]        misalign_addr,
  output logic                   halted,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Number of low PC bits that must be zero for an aligned instruction.
  localparam int ALIGN_BITS = (INST_BYTES == 2) ? 1 : 2;
  localparam logic [PC_W-1:0] RESET_PC_T = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] STEP       = PC_W'(INST_BYTES);
  localparam logic [PC_W-1:0] ALIGN_MASK = {PC_W{1'b1}} << ALIGN_BITS;

  state_t          state;
  logic [PC_W-1:0] pc_q;
  logic            valid_q;

  logic            branch_taken;
  logic            jal_taken;
  logic            jalr_taken;
  logic            redirect;
  logic [PC_W-1:0] rel_target;
  logic [PC_W-1:0] jalr_target;
  logic [PC_W-1:0] redirect_target;
  logic            target_misaligned;
  logic [PC_W-1:0] trap_target;
  logic [PC_W-1:0] seq_pc;

  assign fetch.fetch_valid = valid_q;
  assign fetch.fetch_pc    = pc_q;
  assign dbg_state         = state;

  // Decode-stage redirect decision and target selection; branches beat jumps.
  always_comb begin
    branch_taken      = 1'b0;
    jal_taken         = 1'b0;
    jalr_taken        = 1'b0;
    redirect          = 1'b0;
    rel_target        = idu_inst_pc + imm;
    jalr_target       = (reg1_rdata + imm) & ~{{(PC_W-1){1'b0}}, 1'b1};
    redirect_target   = rel_target;
    target_misaligned = 1'b0;
    trap_target       = trap_pc & ALIGN_MASK;
    seq_pc            = pc_q + STEP;

    branch_taken = ((branch == `BRAN_TYPE_A) &&  zero) ||
                   ((branch == `BRAN_TYPE_B) && !zero);
    jal_taken    = (jump == `JUMP_JAL);
    jalr_taken   = (jump == `JUMP_JALR);
    redirect     = branch_taken || jal_taken || jalr_taken;

    if (branch_taken || jal_taken) begin
      redirect_target = rel_target;
    end else if (jalr_taken) begin
      redirect_target = jalr_target;
    end

    target_misaligned = |(redirect_target & ~ALIGN_MASK);
  end

  // Control FSM with registered PC, request valid and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BOOT;
      pc_q          <= RESET_PC_T;
      valid_q       <= 1'b0;
      flush         <= 1'b0;
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
      halted        <= 1'b0;
    end else begin
      // Pulses default low and are only raised for the cycle after their cause.
      flush        <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        BOOT: begin
          // One idle cycle so the first request follows reset release cleanly.
          state   <= RUN;
          valid_q <= 1'b1;
        end

        RUN: begin
          if (trap_valid) begin
            // Trap wins over everything, including a misaligned redirect.
            pc_q  <= trap_target;
            flush <= 1'b1;
          end else if (redirect) begin
            flush <= 1'b1;
            if (target_misaligned) begin
              misalign_err  <= 1'b1;
              misalign_addr <= redirect_target;
              state         <= HALT;
              valid_q       <= 1'b0;
              halted        <= 1'b1;
            end else begin
              pc_q <= redirect_target;
            end
          end else if (stall) begin
            pc_q <= pc_q;
          end else if (valid_q && fetch.fetch_ready) begin
            // Modulo 2^PC_W: the top address wraps to zero silently.
            pc_q <= seq_pc;
          end
        end

        HALT: begin
          // Only a trap can restart fetch; redirects and stall are ignored.
          if (trap_valid) begin
            pc_q    <= trap_target;
            flush   <= 1'b1;
            state   <= RUN;
            valid_q <= 1'b1;
            halted  <= 1'b0;
          end
        end

        default: begin
          state   <= BOOT;
          pc_q    <= RESET_PC_T;
          valid_q <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a 32-bit instance with RESET_PC=0x8000_0000 and a
// 16-bit instance used for the address wrap check.

`ifndef BRAN_TYPE_A
`define BRAN_TYPE_A 2'd1
`endif
`ifndef BRAN_TYPE_B
`define BRAN_TYPE_B 2'd2
`endif
`ifndef JUMP_JAL
`define JUMP_JAL 2'd1
`endif
`ifndef JUMP_JALR
`define JUMP_JALR 2'd2
`endif

module tb_pc_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall;
  logic [1:0]  branch;
  logic        zero;
  logic [1:0]  jump;
  logic [31:0] reg1_rdata;
  logic [31:0] imm;
  logic [31:0] idu_inst_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        ready;
  logic        flush;
  logic        misalign_err;
  logic [31:0] misalign_addr;
  logic        halted;
  logic [1:0]  dbg_state;

  logic        rst16;
  logic [15:0] zero16;
  logic        flush16;
  logic        err16;
  logic [15:0] addr16;
  logic        halted16;
  logic [1:0]  state16;

  int n_checks = 0;
  int n_fail   = 0;

  pc_gen_if #(.PC_W(32)) f32 ();
  pc_gen_if #(.PC_W(16)) f16 ();

  assign f32.fetch_ready = ready;
  assign f16.fetch_ready = 1'b1;

  pc_gen #(.PC_W(32), .RESET_PC(32'h8000_0000), .INST_BYTES(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .zero(zero),
    .jump(jump), .reg1_rdata(reg1_rdata), .imm(imm), .idu_inst_pc(idu_inst_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .fetch(f32.master),
    .flush(flush), .misalign_err(misalign_err), .misalign_addr(misalign_addr),
    .halted(halted), .dbg_state(dbg_state)
  );

  pc_gen #(.PC_W(16), .RESET_PC(32'h0000_FFF0), .INST_BYTES(4)) dut16 (
    .clk(clk), .rst(rst16), .stall(1'b0), .branch(2'd0), .zero(1'b0),
    .jump(2'd0), .reg1_rdata(zero16), .imm(zero16), .idu_inst_pc(zero16),
    .trap_valid(1'b0), .trap_pc(zero16), .fetch(f16.master),
    .flush(flush16), .misalign_err(err16), .misalign_addr(addr16),
    .halted(halted16), .dbg_state(state16)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch = 0; zero = 0; jump = 0;
    reg1_rdata = 0; imm = 0; idu_inst_pc = 0;
    trap_valid = 0; trap_pc = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; ready = 1; clear_inputs();
    tick(); tick();
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    n_checks++; if (f32.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", f32.fetch_valid); end
    n_checks++; if (f32.fetch_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pc got %h exp 80000000", f32.fetch_pc); end
    n_checks++; if ({flush, misalign_err, halted} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {flush, misalign_err, halted}); end
    n_checks++; if (misalign_addr !== 32'h0) begin n_fail++; $display("FAIL reset_maddr got %h exp 0", misalign_addr); end
    rst = 0;
    n_checks++; if (f32.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b exp 0", f32.fetch_valid); end
    tick();
    n_checks++; if (f32.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL run_valid got %b exp 1", f32.fetch_valid); end
    n_checks++; if (f32.fetch_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL first_pc got %h exp 80000000", f32.fetch_pc); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL boot_flush got %b exp 0", flush); end
    tick();
    n_checks++; if (f32.fetch_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL seq_pc1 got %h exp 80000004", f32.fetch_pc); end
    tick();
    n_checks++; if (f32.fetch_pc !== 32'h8000_0008) begin n_fail++; $display("FAIL seq_pc2 got %h exp 80000008", f32.fetch_pc); end
  endtask

  task automatic test_ready_hold();
    // Trap to 0x13: low two bits are dropped, so fetch resumes at 0x10.
    trap_valid = 1; trap_pc = 32'h13;
    tick();
    n_checks++; if (f32.fetch_pc !== 32'h10) begin n_fail++; $display("FAIL trap_align got %h exp 10", f32.fetch_pc); end
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL trap_flush got %b exp 1", flush); end
    trap_valid = 0; trap_pc = 0; ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (f32.fetch_pc !== 32'h10 || f32.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL ready_low_hold got %h/%b exp 10/1", f32.fetch_pc, f32.fetch_valid); end
    end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL flush_single got %b exp 0", flush); end
    ready = 1;
    tick();
    n_checks++; if (f32.fetch_pc !== 32'h14) begin n_fail++; $display("FAIL ready_resume got %h exp 14", f32.fetch_pc); end
    ready = 0;
  endtask

  task automatic test_branch();
    stall = 1; ready = 0;
    branch = `BRAN_TYPE_B; zero = 0; idu_inst_pc = 32'h40; imm = 32'hFFFF_FFF8;
    tick();
    n_checks++; if (f32.fetch_pc !== 32'h38) begin n_fail++; $display("FAIL bran_b_pc got %h exp 38", f32.fetch_pc); end
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL bran_b_flush got %b exp 1", flush); end
    branch = 0;
    tick();
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL bran_flush_once got %b exp 0", flush); end
    branch = `BRAN_TYPE_B; zero = 1; idu_inst_pc = 32'h40; imm = 32'hFFFF_FFF8;
    tick();
    n_checks++; if (f32.fetch_pc !== 32'h38 || flush !== 1'b0) begin n_fail++; $display("FAIL bran_b_not_taken got %h/%b exp 38/0", f32.fetch_pc, flush); end
    // Branch A taken together with JALR: branch target must win.
    branch = `BRAN_TYPE_A; zero = 1; idu_inst_pc = 32'h100; imm = 32'h20;
    jump = `JUMP_JALR; reg1_rdata = 32'h5000;
    tick();
    n_checks++; if (f32.fetch_pc !== 32'h120) begin n_fail++; $display("FAIL bran_over_jump got %h exp 120", f32.fetch_pc); end
    clear_inputs(); stall = 1;
    jump = `JUMP_JAL; idu_inst_pc = 32'h1000; imm = 32'h10;
    tick();
    n_checks++; if (f32.fetch_pc !== 32'h1010 || flush !== 1'b1) begin n_fail++; $display("FAIL jal_pc got %h/%b exp 1010/1", f32.fetch_pc, flush); end
    clear_inputs();
  endtask

  task automatic test_misalign();
    jump = `JUMP_JALR; reg1_rdata = 32'h103; imm = 32'h0;
    tick();
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_err got %b exp 1", misalign_err); end
    n_checks++; if (misalign_addr !== 32'h102) begin n_fail++; $display("FAIL mis_addr got %h exp 102", misalign_addr); end
    n_checks++; if (halted !== 1'b1 || f32.fetch_valid !== 1'b0 || dbg_state !== 2'd2) begin n_fail++; $display("FAIL mis_halt got %b/%b/%0d exp 1/0/2", halted, f32.fetch_valid, dbg_state); end
    n_checks++; if (f32.fetch_pc !== 32'h1010 || flush !== 1'b1) begin n_fail++; $display("FAIL mis_pc got %h/%b exp 1010/1", f32.fetch_pc, flush); end
    // Redirect while halted is ignored.
    jump = `JUMP_JAL; idu_inst_pc = 32'h0; imm = 32'h40; reg1_rdata = 0;
    tick();
    n_checks++; if (f32.fetch_pc !== 32'h1010 || misalign_err !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL halt_ignore got %h/%b/%b exp 1010/0/0", f32.fetch_pc, misalign_err, flush); end
    n_checks++; if (halted !== 1'b1 || misalign_addr !== 32'h102) begin n_fail++; $display("FAIL halt_hold got %b/%h exp 1/102", halted, misalign_addr); end
    clear_inputs();
    trap_valid = 1; trap_pc = 32'h200;
    tick();
    n_checks++; if (f32.fetch_pc !== 32'h200 || flush !== 1'b1) begin n_fail++; $display("FAIL halt_trap got %h/%b exp 200/1", f32.fetch_pc, flush); end
    n_checks++; if (halted !== 1'b0 || f32.fetch_valid !== 1'b1 || dbg_state !== 2'd1) begin n_fail++; $display("FAIL halt_exit got %b/%b/%0d exp 0/1/1", halted, f32.fetch_valid, dbg_state); end
    clear_inputs();
  endtask

  task automatic test_trap_vs_redirect();
    trap_valid = 1; trap_pc = 32'h300; jump = `JUMP_JAL; idu_inst_pc = 32'h0; imm = 32'h20;
    tick();
    n_checks++; if (f32.fetch_pc !== 32'h300 || misalign_err !== 1'b0) begin n_fail++; $display("FAIL trap_jal got %h/%b exp 300/0", f32.fetch_pc, misalign_err); end
    trap_pc = 32'h400; imm = 32'h22;
    tick();
    n_checks++; if (f32.fetch_pc !== 32'h400 || misalign_err !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL trap_mis_jal got %h/%b/%b exp 400/0/0", f32.fetch_pc, misalign_err, halted); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_stall();
    stall = 1; ready = 1; trap_valid = 1; trap_pc = 32'h500; rst = 1;
    tick();
    n_checks++; if (dbg_state !== 2'd0 || f32.fetch_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_mid got %0d/%h exp 0/80000000", dbg_state, f32.fetch_pc); end
    n_checks++; if (f32.fetch_valid !== 1'b0 || flush !== 1'b0 || misalign_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_out got %b/%b/%h exp 0/0/0", f32.fetch_valid, flush, misalign_addr); end
    rst = 0; clear_inputs();
  endtask

  task automatic test_wrap16();
    rst16 = 0;
    tick();
    n_checks++; if (f16.fetch_pc !== 16'hFFF0 || f16.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL w16_start got %h/%b exp fff0/1", f16.fetch_pc, f16.fetch_valid); end
    tick(); tick(); tick();
    n_checks++; if (f16.fetch_pc !== 16'hFFFC) begin n_fail++; $display("FAIL w16_top got %h exp fffc", f16.fetch_pc); end
    tick();
    n_checks++; if (f16.fetch_pc !== 16'h0000 || err16 !== 1'b0 || halted16 !== 1'b0) begin n_fail++; $display("FAIL w16_wrap got %h/%b/%b exp 0000/0/0", f16.fetch_pc, err16, halted16); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    zero16 = '0;
    rst16  = 1;
    test_reset();
    test_ready_hold();
    test_branch();
    test_misalign();
    test_trap_vs_redirect();
    test_reset_mid_stall();
    test_wrap16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
